// File: rtl/vedic_seq_mul.sv
// Sequenced multi-nibble multiplier time-sharing one 4x4 Vedic core (vedic4mul).
// Optional macro VEDIC_SEQ_ZERO_SKIP_EN: zero operands skip straight to DONE.

module vedic4mul (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);
    // 2x2 Vedic (Urdhva-Tiryagbhyam) cell: AND partials plus half adders.
    function automatic logic [3:0] vedic2(input logic [1:0] x, input logic [1:0] y);
        logic t1, t2, c1, t3;
        t1 = x[1] & y[0];
        t2 = x[0] & y[1];
        c1 = t1 & t2;
        t3 = x[1] & y[1];
        return {t3 & c1, t3 ^ c1, t1 ^ t2, x[0] & y[0]};
    endfunction

    logic [3:0] q0, q1, q2, q3;

    assign q0 = vedic2(a[1:0], b[1:0]);
    assign q1 = vedic2(a[3:2], b[1:0]);
    assign q2 = vedic2(a[1:0], b[3:2]);
    assign q3 = vedic2(a[3:2], b[3:2]);
    assign p  = {4'b0, q0} + {2'b0, q1, 2'b0} + {2'b0, q2, 2'b0} + {q3, 4'b0};
endmodule

module vedic_seq_mul #(
    parameter int N_DIG = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*N_DIG-1:0]   a,
    input  logic [4*N_DIG-1:0]   b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*N_DIG-1:0]   product,
    output logic                 busy
);
    localparam int W  = 4 * N_DIG;
    localparam int PW = 2 * W;
    localparam int CW = (N_DIG > 1) ? $clog2(N_DIG) : 1;
    localparam logic [CW-1:0] LAST = CW'(N_DIG - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_nxt;
    logic            accept;
    logic            last;
    logic [W-1:0]    a_reg, b_reg;
    logic [PW-1:0]   acc, acc_nxt;
    logic [CW-1:0]   i, j;
    logic [CW:0]     ij_sum;
    logic [CW+2:0]   shamt;
    logic [3:0]      core_a, core_b;
    logic [7:0]      core_p;

    assign core_a  = a_reg[{i, 2'b00} +: 4];
    assign core_b  = b_reg[{j, 2'b00} +: 4];
    assign ij_sum  = {1'b0, i} + {1'b0, j};
    assign shamt   = {ij_sum, 2'b00};
    assign acc_nxt = acc + (PW'(core_p) << shamt);
    assign last    = (i == LAST) && (j == LAST);

    vedic4mul u_core (
        .a (core_a),
        .b (core_b),
        .p (core_p)
    );

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    accept = 1'b1;
`ifdef VEDIC_SEQ_ZERO_SKIP_EN
                    state_nxt = ((a == '0) || (b == '0)) ? DONE : RUN;
`else
                    state_nxt = RUN;
`endif
                end
            end
            RUN:     if (last) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, nibble walk (i inner, j outer) and accumulate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg   <= '0;
            b_reg   <= '0;
            acc     <= '0;
            product <= '0;
            i       <= '0;
            j       <= '0;
        end else if (accept) begin
            a_reg <= a;
            b_reg <= b;
            acc   <= '0;
            i     <= '0;
            j     <= '0;
`ifdef VEDIC_SEQ_ZERO_SKIP_EN
            if ((a == '0) || (b == '0)) product <= '0;
`endif
        end else if (state == RUN) begin
            acc <= acc_nxt;
            if (last) begin
                product <= acc_nxt;
                i       <= '0;
                j       <= '0;
            end else if (i == LAST) begin
                i <= '0;
                j <= j + 1'b1;
            end else begin
                i <= i + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_vedic_seq_mul.sv
// Randomized and directed bench for vedic_seq_mul against an arithmetic reference model.
// Honors VEDIC_SEQ_ZERO_SKIP_EN for the expected zero-operand latency.

module tb_vedic_seq_mul;
    localparam int N  = 2;
    localparam int W  = 4 * N;
    localparam int PW = 2 * W;
`ifdef VEDIC_SEQ_ZERO_SKIP_EN
    localparam bit ZS = 1'b1;
`else
    localparam bit ZS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready;
    logic [W-1:0]  a, b;
    logic          out_valid, out_ready;
    logic [PW-1:0] product;
    logic          busy;

    int n_chk  = 0;
    int n_pass = 0;

    vedic_seq_mul #(.N_DIG(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic logic [63:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
        return 64'(x) * 64'(y);
    endfunction

    function automatic int ref_lat(input logic [W-1:0] x, input logic [W-1:0] y);
        return (ZS && (x == '0 || y == '0)) ? 0 : N * N;
    endfunction

    // Present operands, wait for acceptance; return after the accept edge (+1).
    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb);
        int wc;
        in_valid = 1'b1;
        a = ta;
        b = tb;
        wc = 0;
        while (!in_ready && wc < 50) begin
            @(posedge clk); #1;
            wc++;
        end
        chk("accept_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
    endtask

    // Count edges after the accept edge until out_valid, bounded.
    task automatic wait_valid(output int edges);
        edges = 0;
        while (!out_valid && edges < 300) begin
            @(posedge clk); #1;
            edges++;
        end
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input int hold);
        int lat;
        logic [63:0] exp_p;
        exp_p = ref_mul(ta, tb);
        out_ready = 1'b0;
        send(ta, tb);
        chk("busy_after_accept", 64'(busy), 64'd1);
        chk("in_ready_busy", 64'(in_ready), 64'd0);
        wait_valid(lat);
        chk("latency", 64'(lat), 64'(ref_lat(ta, tb)));
        chk("product", 64'(product), exp_p);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_product", 64'(product), exp_p);
            chk("hold_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("handoff_valid", 64'(out_valid), 64'd0);
        chk("handoff_in_ready", 64'(in_ready), 64'd1);
        chk("handoff_busy", 64'(busy), 64'd0);
        chk("retained_product", 64'(product), exp_p);
    endtask

    initial begin
        int lat;
        int spurious;
        logic [W-1:0] ra, rb;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_product", 64'(product), 64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        run_op(W'(8'h12), W'(8'h34), 0);
        run_op('1, '1, 5);
        run_op('0, W'(8'hAB), 1);

        // Back-to-back with in_valid held through the output handshake.
        out_ready = 1'b1;
        send(W'(8'h0F), W'(8'h10));
        in_valid = 1'b1;
        a = W'(8'hA5);
        b = W'(8'h5A);
        wait_valid(lat);
        chk("b2b_first", 64'(product), ref_mul(W'(8'h0F), W'(8'h10)));
        @(posedge clk); #1;
        chk("b2b_no_accept_busy", 64'(busy), 64'd0);
        chk("b2b_idle_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("b2b_second_accept", 64'(busy), 64'd1);
        wait_valid(lat);
        chk("b2b_second_lat", 64'(lat), 64'(N * N));
        chk("b2b_second", 64'(product), ref_mul(W'(8'hA5), W'(8'h5A)));
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("b2b_done", 64'(out_valid), 64'd0);

        // Abort in the second RUN cycle.
        send(W'(8'hC3), W'(8'h7E));
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_product", 64'(product), 64'd0);
        chk("abort_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        spurious = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (out_valid || busy) spurious++;
        end
        chk("abort_no_spurious", 64'(spurious), 64'd0);
        run_op(W'(8'h03), W'(8'h05), 0);

        for (int n = 0; n < 24; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            if ($urandom_range(0, 5) == 0) ra = '0;
            if ($urandom_range(0, 5) == 0) rb = '0;
            run_op(ra, rb, $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
